// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the segment-display update arbiter.
package seg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_SEG_W        = 7;
  localparam int DEF_DWELL_CYCLES = 16;

  // Blank display pattern; sliced down to SEG_W at the point of use.
  localparam logic [31:0] SEG_BLANK = 32'hFFFF_FFFF;

endpackage

// File: rtl/seg_update_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int c;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    // Explicit wrap compare so non-power-of-two N never indexes past N-1.
    for (int k = 1; k <= N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        idx    = IW'(c);
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_update_arbiter.sv
// Round-robin arbiter sharing one 7-segment latch, with a load strobe and dwell hold-off.
// Optional macro SEG_ARB_PREEMPT_EN lets requester 0 abort another owner's dwell.
module seg_update_arbiter
  import seg_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int SEG_W        = DEF_SEG_W,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*SEG_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       io_flag,
  output logic [SEG_W-1:0]           seg_data,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DWELL_CYCLES + 1);

  // Handshake: req[i] with req_data slice i is held until gnt[i]=1; that cycle is the accept.
  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic [IW-1:0]        owner_q, owner_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;
  logic [IW-1:0]        pick_ptr;
  logic                 preempt;

`ifdef SEG_ARB_PREEMPT_EN
  logic abort_q;
  assign preempt  = (state_q == DWELL) && req[0] && (owner_q != '0);
  // Right after an abort, pointing at NUM_REQ-1 puts requester 0 first.
  assign pick_ptr = abort_q ? IW'(NUM_REQ - 1) : ptr_q;
  always_ff @(posedge clk) begin
    if (!reset) abort_q <= 1'b0;
    else        abort_q <= preempt;
  end
`else
  assign preempt  = 1'b0;
  assign pick_ptr = ptr_q;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      seg_q   <= SEG_BLANK[SEG_W-1:0];
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          seg_d   = req_data[int'(pick_idx)*SEG_W +: SEG_W];
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = DWELL;
        cnt_d   = CW'(DWELL_CYCLES - 1);
      end
      DWELL: begin
        if (preempt || cnt_q == '0) state_d = IDLE;
        else                        cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt      = (state_q == IDLE && reset) ? pick_gnt : '0;
  assign io_flag  = (state_q == ISSUE);
  assign seg_data = seg_q;
  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;

endmodule

// File: tb/tb_seg_update_arbiter.sv
// Table-driven bench for seg_update_arbiter (NUM_REQ=4, SEG_W=7, DWELL_CYCLES=16).
module tb_seg_update_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [27:0] req_data;
  logic [3:0]  gnt;
  logic        io_flag;
  logic [6:0]  seg_data;
  logic        busy;
  logic [1:0]  owner;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  seg_update_arbiter #(.NUM_REQ(4), .SEG_W(7), .DWELL_CYCLES(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .io_flag  (io_flag),
    .seg_data (seg_data),
    .busy     (busy),
    .owner    (owner)
  );

  typedef struct {
    int         n;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       io;
    logic [6:0] seg;
    logic       busy;
    logic [1:0] own;
  } vec_t;

  vec_t tbl[$];
  logic [6:0] pats [4];
  logic [6:0] m_seg;
  logic [1:0] m_own;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  task automatic run_vec(input vec_t v);
    for (int c = 0; c < v.n; c++) begin
      reset = v.rst;
      req   = v.req;
      #2;
      chk("gnt", 32'(gnt), 32'(v.gnt));
      chk("io_flag", 32'(io_flag), 32'(v.io));
      chk("seg_data", 32'(seg_data), 32'(v.seg));
      chk("busy", 32'(busy), 32'(v.busy));
      chk("owner", 32'(owner), 32'(v.own));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic vec_t mk(int n, logic r, logic [3:0] rq, logic [3:0] g, logic io,
                              logic [6:0] s, logic b, logic [1:0] o);
    vec_t v;
    v.n = n; v.rst = r; v.req = rq; v.gnt = g; v.io = io; v.seg = s; v.busy = b; v.own = o;
    return v;
  endfunction

  task automatic add(int n, logic r, logic [3:0] rq, logic [3:0] g, logic io,
                     logic [6:0] s, logic b, logic [1:0] o);
    tbl.push_back(mk(n, r, rq, g, io, s, b, o));
  endtask

  // Grant cycle, one strobe cycle, sixteen dwell cycles; tracks last shown pattern/owner.
  task automatic grant_seq(logic [3:0] rq_g, logic [3:0] rq_after, int i);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << i;
    add(1,  1'b1, rq_g,     one_hot, 1'b0, m_seg,   1'b0, m_own);
    add(1,  1'b1, rq_after, 4'b0000, 1'b1, pats[i], 1'b1, 2'(i));
    add(16, 1'b1, rq_after, 4'b0000, 1'b0, pats[i], 1'b1, 2'(i));
    m_seg = pats[i];
    m_own = 2'(i);
  endtask

  task automatic step(int n, logic r, logic [3:0] rq, logic [3:0] g, logic io,
                      logic [6:0] s, logic b, logic [1:0] o);
    run_vec(mk(n, r, rq, g, io, s, b, o));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pats[0] = 7'h40; pats[1] = 7'h79; pats[2] = 7'h24; pats[3] = 7'h30;
    req_data = {pats[3], pats[2], pats[1], pats[0]};
    m_seg = 7'h7F;
    m_own = 2'd0;

    // Reset held low, then idle with no requests.
    add(3, 1'b0, 4'b0000, 4'b0000, 1'b0, 7'h7F, 1'b0, 2'd0);
    add(4, 1'b1, 4'b0000, 4'b0000, 1'b0, 7'h7F, 1'b0, 2'd0);

`ifdef SEG_ARB_PREEMPT_EN
    // Requester 0 held would abort every other owner's dwell, so contend without it.
    grant_seq(4'b1110, 4'b1110, 1);
    grant_seq(4'b1110, 4'b1110, 2);
    grant_seq(4'b1110, 4'b1110, 3);
    grant_seq(4'b1110, 4'b1110, 1);
`else
    grant_seq(4'b1111, 4'b1111, 0);
    grant_seq(4'b1111, 4'b1111, 1);
    grant_seq(4'b1111, 4'b1111, 2);
    grant_seq(4'b1111, 4'b1111, 3);
    grant_seq(4'b1111, 4'b1111, 0);
`endif

    // Lone requester held: regranted exactly DWELL_CYCLES+2 cycles later.
    grant_seq(4'b0001, 4'b0001, 0);
    grant_seq(4'b0001, 4'b0000, 0);
    add(2, 1'b1, 4'b0000, 4'b0000, 1'b0, m_seg, 1'b0, m_own);

    // Grant requester 2, then requesters 0/1 wait through its dwell (ptr=2 wraps to 0).
    add(1, 1'b1, 4'b0100, 4'b0100, 1'b0, m_seg, 1'b0, m_own);
    add(1, 1'b1, 4'b0000, 4'b0000, 1'b1, 7'h24, 1'b1, 2'd2);
`ifdef SEG_ARB_PREEMPT_EN
    add(1, 1'b1, 4'b0011, 4'b0000, 1'b0, 7'h24, 1'b1, 2'd2);
`else
    add(16, 1'b1, 4'b0011, 4'b0000, 1'b0, 7'h24, 1'b1, 2'd2);
`endif
    m_seg = 7'h24;
    m_own = 2'd2;
    grant_seq(4'b0011, 4'b0011, 0);
    add(1, 1'b1, 4'b0011, 4'b0010, 1'b0, 7'h40, 1'b0, 2'd0);
    add(1, 1'b1, 4'b0000, 4'b0000, 1'b1, 7'h79, 1'b1, 2'd1);
    // Requester 3 asserts only during the dwell and is dropped before any grant.
    add(5,  1'b1, 4'b1000, 4'b0000, 1'b0, 7'h79, 1'b1, 2'd1);
    add(11, 1'b1, 4'b0000, 4'b0000, 1'b0, 7'h79, 1'b1, 2'd1);
    add(3,  1'b1, 4'b0000, 4'b0000, 1'b0, 7'h79, 0, 2'd1);

    reset = 1'b0;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    foreach (tbl[k]) run_vec(tbl[k]);

    // Reset in the middle of a dwell owned by requester 1 (ptr=1).
    step(1, 1'b1, 4'b0010, 4'b0010, 1'b0, 7'h79, 1'b0, 2'd1);
    step(1, 1'b1, 4'b0000, 4'b0000, 1'b1, 7'h79, 1'b1, 2'd1);
    step(5, 1'b1, 4'b0000, 4'b0000, 1'b0, 7'h79, 1'b1, 2'd1);
    step(1, 1'b0, 4'b0111, 4'b0000, 1'b0, 7'h79, 1'b1, 2'd1);
    step(1, 1'b0, 4'b0111, 4'b0000, 1'b0, 7'h7F, 1'b0, 2'd0);
    // After release the pointer is back at NUM_REQ-1, so requester 0 wins.
    step(1, 1'b1, 4'b0111, 4'b0001, 1'b0, 7'h7F, 1'b0, 2'd0);
    step(1, 1'b1, 4'b0000, 4'b0000, 1'b1, 7'h40, 1'b1, 2'd0);
    step(3, 1'b1, 4'b0000, 4'b0000, 1'b0, 7'h40, 1'b1, 2'd0);

    // Reset during the strobe cycle kills io_flag at that edge.
    step(13, 1'b1, 4'b0000, 4'b0000, 1'b0, 7'h40, 1'b1, 2'd0);
    step(1, 1'b1, 4'b1000, 4'b1000, 1'b0, 7'h40, 1'b0, 2'd0);
    step(1, 1'b0, 4'b0000, 4'b0000, 1'b1, 7'h30, 1'b1, 2'd3);
    step(2, 1'b1, 4'b0000, 4'b0000, 1'b0, 7'h7F, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_update_arbiter.md
Name: seg_update_arbiter

Overview:
- Shares one 7-segment display latch (io_flag/in load port, blank = all ones) between NUM_REQ requesters.
- Round-robin arbitration, one request serviced at a time.
- Drives a single-cycle load strobe, then enforces a minimum dwell time before the next update.
- Sits between the CPU I/O decode / debug sources and the display latch.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- SEG_W, 7: segment pattern width.
- DWELL_CYCLES, 16: cycles the display must hold a pattern before the next grant (>=1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- req  in  NUM_REQ  per-requester update request; held with data until granted.
- req_data  in  NUM_REQ*SEG_W  packed patterns; requester i occupies bits [i*SEG_W +: SEG_W].
- gnt  out  NUM_REQ  one-hot accept; request i accepted in the cycle gnt[i]=1.
- io_flag  out  1  load strobe to the display latch.
- seg_data  out  SEG_W  pattern presented to the latch.
- busy  out  1  high in ISSUE and DWELL.
- owner  out  clog2(NUM_REQ)  index of the last granted requester.

Behaviour:
- Reset (reset=0 at an edge) values:
  - state=IDLE, io_flag=0, seg_data=all ones, busy=0, owner=0.
  - Priority pointer=NUM_REQ-1, so requester 0 has first priority.
  - Dwell counter=0; gnt=0 while reset is low.
- FSM states: IDLE, ISSUE, DWELL.
- IDLE:
  - gnt is combinational from state and req.
  - Winner = first i with req[i]=1, searching ptr+1, ptr+2, ... with wrap modulo NUM_REQ.
  - gnt[winner]=1 in the same cycle.
  - At the edge: capture req_data[winner] into seg_data, owner<=winner, ptr<=winner, go to ISSUE.
  - No req: stay in IDLE, gnt=0.
- ISSUE (exactly 1 cycle):
  - io_flag=1, seg_data holds the captured value.
  - Next state DWELL; counter<=DWELL_CYCLES-1.
- DWELL:
  - io_flag=0; counter decrements each cycle.
  - When counter==0, go to IDLE next edge.
  - gnt=0 throughout.
- seg_data holds its last value outside ISSUE; never re-blanked except by reset.
- Latency: req accepted at cycle T -> io_flag at T+1 -> DWELL over T+2..T+1+DWELL_CYCLES -> earliest next gnt at T+2+DWELL_CYCLES.
- Fairness: a continuously requesting winner is skipped while any other req is high. With one requester active, it is regranted every DWELL_CYCLES+2 cycles.
- A request deasserted before grant is dropped silently; no stored state.
- Simultaneous requests: only one is granted per IDLE cycle; the rest wait.
- Reset mid-ISSUE or mid-DWELL: io_flag forced 0 that edge, all state returns to reset values, pending requests restart arbitration.
- Arithmetic:
  - Counter width clog2(DWELL_CYCLES+1).
  - Pointer increment wraps NUM_REQ-1 -> 0 (non-power-of-two NUM_REQ handled by explicit compare).

Optional Feature:
- Macro: SEG_ARB_PREEMPT_EN.
- Defined:
  - In DWELL, if req[0]=1 and owner!=0, the dwell aborts and the next state is IDLE.
  - In the IDLE cycle immediately following an abort, requester 0 wins regardless of the pointer.
  - Ptr is updated to 0 as normal.
- Undefined: requester 0 has no special treatment; the dwell always completes.

Decomposition:
- Package seg_arb_pkg:
  - state enum (IDLE, ISSUE, DWELL).
  - SEG_BLANK constant (all ones).
  - Default parameter constants.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, index, any-valid.
  - Instanced once.

Test Plan:
- Reset held low 3 cycles, then released, no req -> io_flag=0, seg_data=7'h7F, gnt=0, busy=0 throughout.
- Single request: req=4'b0001, req_data[0]=7'h40 at T -> gnt=0001 at T; io_flag=1, seg_data=7'h40 at T+1; next gnt no earlier than T+18 (DWELL_CYCLES=16).
- Contention: req=4'b1111 held continuously -> grant order 0,1,2,3,0; grants spaced 18 cycles; owner tracks each.
- Wrap and skip: ptr=2, req=4'b0011 -> requester 0 granted, then requester 1.
- Reset mid-DWELL: reset=0 at cycle 5 of dwell -> next edge busy=0, seg_data=7'h7F; after release, req[0] is granted first.
- SEG_ARB_PREEMPT_EN defined: owner=2 in DWELL, req[0] asserted -> IDLE next edge, gnt=0001 that cycle, io_flag one cycle later. Undefined: same stimulus waits the full 16 cycles.
